// File: rtl/bin_pkg.sv
// Shared geometry and types for the binned-mask upscaler.
package bin_pkg;
  localparam int H_RES     = 1280;
  localparam int V_RES     = 720;
  localparam int BIN       = 4;
  localparam int BIN_SHIFT = $clog2(BIN);
  localparam int H_BINS    = H_RES / BIN;
  localparam int V_BINS    = V_RES / BIN;
  localparam int N_BINS    = H_BINS * V_BINS;
  localparam int ADDR_W    = 16;
  localparam int HPIX_W    = 11;
  localparam int VPIX_W    = 10;
  localparam int HBIN_W    = 9;
  localparam int VBIN_W    = 8;

  typedef logic [ADDR_W-1:0] bin_addr_t;

  typedef struct packed {
    logic [HPIX_W-1:0] h;
    logic [VPIX_W-1:0] v;
  } pix_coord_t;
endpackage

// File: rtl/bin_bank_ram.sv
// One bank of bin storage: 1-bit wide, one write port, registered read port (read-first).
module bin_bank_ram
  import bin_pkg::*;
#(
  parameter int DEPTH = N_BINS
) (
  input  logic      clk_in,
  input  logic      we_in,
  input  bin_addr_t waddr_in,
  input  logic      wdata_in,
  input  bin_addr_t raddr_in,
  output logic      rdata_out
);
  logic mem [DEPTH];
  logic rdata_d, rdata_q;

  always_comb begin
    rdata_d = mem[raddr_in];
  end

  always_ff @(posedge clk_in) begin
    if (we_in) mem[waddr_in] <= wdata_in;
    rdata_q <= rdata_d;
  end

  assign rdata_out = rdata_q;
endmodule

// File: rtl/bin_upscaler.sv
// Captures the binned mask into bin-resolution storage and replays it at pixel rate.
// DOUBLE_BUFFER_EN selects ping-pong banks with frame swap at (0,0); otherwise a single tearing bank.
module bin_upscaler
  import bin_pkg::*;
(
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              bin_valid_in,
  input  logic [HBIN_W-1:0] bin_hcount_in,
  input  logic [VBIN_W-1:0] bin_vcount_in,
  input  logic              bin_data_in,
  input  logic [HPIX_W-1:0] hcount_in,
  input  logic [VPIX_W-1:0] vcount_in,
  output logic              valid_out,
  output logic [HPIX_W-1:0] hcount_out,
  output logic [VPIX_W-1:0] vcount_out,
  output logic              pixel_out,
  output logic              frame_swap_out,
  output logic              dropped_out
);
  logic       wr_in_range, rd_in_range, wr_acc, rd_bit;
  bin_addr_t  wr_addr, rd_addr_d, rd_addr_q;
  pix_coord_t pix1_d, pix1_q, pix2_d, pix2_q;
  logic       inr1_d, inr1_q, inr2_d, inr2_q;
  logic       shown_d, shown_q, shown1_d, shown1_q, shown2_d, shown2_q;

  always_comb begin
    wr_in_range = (bin_hcount_in < HBIN_W'(H_BINS)) && (bin_vcount_in < VBIN_W'(V_BINS));
    wr_addr     = ADDR_W'(bin_vcount_in) * ADDR_W'(H_BINS) + ADDR_W'(bin_hcount_in);
    rd_in_range = (hcount_in < HPIX_W'(H_RES)) && (vcount_in < VPIX_W'(V_RES));
    // Off-screen reads park on address 0 so the RAM is never indexed past its depth.
    rd_addr_d   = '0;
    if (rd_in_range)
      rd_addr_d = ADDR_W'(vcount_in >> BIN_SHIFT) * ADDR_W'(H_BINS) + ADDR_W'(hcount_in >> BIN_SHIFT);
    pix1_d   = '{h: hcount_in, v: vcount_in};
    pix2_d   = pix1_q;
    inr1_d   = rd_in_range;
    inr2_d   = inr1_q;
    shown2_d = shown1_q;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      rd_addr_q <= '0;
      pix1_q    <= '0;
      pix2_q    <= '0;
      inr1_q    <= 1'b0;
      inr2_q    <= 1'b0;
      shown_q   <= 1'b0;
      shown1_q  <= 1'b0;
      shown2_q  <= 1'b0;
    end else begin
      rd_addr_q <= rd_addr_d;
      pix1_q    <= pix1_d;
      pix2_q    <= pix2_d;
      inr1_q    <= inr1_d;
      inr2_q    <= inr2_d;
      shown_q   <= shown_d;
      shown1_q  <= shown1_d;
      shown2_q  <= shown2_d;
    end
  end

`ifdef DOUBLE_BUFFER_EN
  logic       read_bank_d, read_bank_q, write_bank_d, write_bank_q;
  logic       frame_ready_d, frame_ready_q, dropped_d, dropped_q;
  logic       swap_d, swap_q, sel1_d, sel1_q, sel2_d, sel2_q;
  logic       swap_now, wr_last;
  logic [1:0] bank_we, bank_rdata;

  always_comb begin
    wr_last  = (bin_hcount_in == HBIN_W'(H_BINS - 1)) && (bin_vcount_in == VBIN_W'(V_BINS - 1));
    swap_now = (hcount_in == '0) && (vcount_in == '0) && frame_ready_q;
    wr_acc   = bin_valid_in && wr_in_range && !frame_ready_q;
    dropped_d = dropped_q || (bin_valid_in && wr_in_range && frame_ready_q);
    frame_ready_d = frame_ready_q;
    if (swap_now)              frame_ready_d = 1'b0;
    else if (wr_acc && wr_last) frame_ready_d = 1'b1;
    read_bank_d  = read_bank_q ^ swap_now;
    write_bank_d = write_bank_q ^ swap_now;
    shown_d      = shown_q || swap_now;
    swap_d       = swap_now;
    // Bank/shown are taken post-swap so the (0,0) pixel already shows the new frame.
    sel1_d   = read_bank_d;
    sel2_d   = sel1_q;
    shown1_d = shown_d;
    bank_we  = {wr_acc && write_bank_q, wr_acc && !write_bank_q} & {2{rst_in}};
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      read_bank_q   <= 1'b0;
      write_bank_q  <= 1'b1;
      frame_ready_q <= 1'b0;
      dropped_q     <= 1'b0;
      swap_q        <= 1'b0;
      sel1_q        <= 1'b0;
      sel2_q        <= 1'b0;
    end else begin
      read_bank_q   <= read_bank_d;
      write_bank_q  <= write_bank_d;
      frame_ready_q <= frame_ready_d;
      dropped_q     <= dropped_d;
      swap_q        <= swap_d;
      sel1_q        <= sel1_d;
      sel2_q        <= sel2_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    bin_bank_ram u_ram (
      .clk_in    (clk_in),
      .we_in     (bank_we[b]),
      .waddr_in  (wr_addr),
      .wdata_in  (bin_data_in),
      .raddr_in  (rd_addr_q),
      .rdata_out (bank_rdata[b])
    );
  end

  assign rd_bit         = bank_rdata[sel2_q];
  assign frame_swap_out = swap_q;
  assign dropped_out    = dropped_q;
`else
  logic ram_we;

  always_comb begin
    wr_acc   = bin_valid_in && wr_in_range;
    shown_d  = shown_q || wr_acc;
    shown1_d = shown_d;
    ram_we   = wr_acc && rst_in;
  end

  bin_bank_ram u_ram (
    .clk_in    (clk_in),
    .we_in     (ram_we),
    .waddr_in  (wr_addr),
    .wdata_in  (bin_data_in),
    .raddr_in  (rd_addr_q),
    .rdata_out (rd_bit)
  );

  assign frame_swap_out = 1'b0;
  assign dropped_out    = 1'b0;
`endif

  assign valid_out  = inr2_q;
  assign hcount_out = pix2_q.h;
  assign vcount_out = pix2_q.v;
  assign pixel_out  = rd_bit & inr2_q & shown2_q;
endmodule

// File: tb/tb_bin_upscaler.sv
// Scoreboard bench for bin_upscaler: directed stimulus pushes expectations, a monitor pops and compares.
module tb_bin_upscaler;
`ifdef DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif
  localparam logic [5:0] M_PIX = 6'b001111;
  localparam logic [5:0] M_ST  = 6'b110000;
  localparam logic [5:0] M_ALL = 6'b111111;

  logic        clk_in = 1'b0, rst_in = 1'b0, bin_valid_in = 1'b0, bin_data_in = 1'b0;
  logic [8:0]  bin_hcount_in = '0;
  logic [7:0]  bin_vcount_in = '0;
  logic [10:0] hcount_in = '0;
  logic [9:0]  vcount_in = '0;
  logic        valid_out, pixel_out, frame_swap_out, dropped_out;
  logic [10:0] hcount_out;
  logic [9:0]  vcount_out;

  typedef struct {
    int          due;
    string       name;
    logic [5:0]  m;
    logic        vld, pix, swp, drp;
    logic [10:0] h;
    logic [9:0]  v;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0, n_chk = 0, n_err = 0;

  bin_upscaler dut (
    .clk_in(clk_in), .rst_in(rst_in), .bin_valid_in(bin_valid_in),
    .bin_hcount_in(bin_hcount_in), .bin_vcount_in(bin_vcount_in), .bin_data_in(bin_data_in),
    .hcount_in(hcount_in), .vcount_in(vcount_in), .valid_out(valid_out),
    .hcount_out(hcount_out), .vcount_out(vcount_out), .pixel_out(pixel_out),
    .frame_swap_out(frame_swap_out), .dropped_out(dropped_out)
  );

  initial forever #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  function automatic void push(input string name, input int due, input logic [5:0] m,
                               input logic vld, input logic pix, input logic [10:0] h,
                               input logic [9:0] v, input logic swp, input logic drp);
    exp_t e;
    e.due = due; e.name = name; e.m = m; e.vld = vld; e.pix = pix;
    e.h = h; e.v = v; e.swp = swp; e.drp = drp;
    exp_q.push_back(e);
  endfunction

  function automatic void check(input exp_t e);
    logic bad;
    bad = 1'b0;
    if (e.m[0] && valid_out      !== e.vld) bad = 1'b1;
    if (e.m[1] && pixel_out      !== e.pix) bad = 1'b1;
    if (e.m[2] && hcount_out     !== e.h)   bad = 1'b1;
    if (e.m[3] && vcount_out     !== e.v)   bad = 1'b1;
    if (e.m[4] && frame_swap_out !== e.swp) bad = 1'b1;
    if (e.m[5] && dropped_out    !== e.drp) bad = 1'b1;
    n_chk++;
    if (bad) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got vld=%b pix=%b h=%0d v=%0d swp=%b drp=%b, want vld=%b pix=%b h=%0d v=%0d swp=%b drp=%b (mask %b)",
               e.name, cyc, valid_out, pixel_out, hcount_out, vcount_out, frame_swap_out, dropped_out,
               e.vld, e.pix, e.h, e.v, e.swp, e.drp, e.m);
    end
  endfunction

  // Monitor: compare every expectation that falls due on this cycle.
  initial forever begin
    @(posedge clk_in);
    #1;
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].due <= cyc) begin
        check(exp_q[i]);
        exp_q.delete(i);
      end
    end
  end

  task automatic tick(input logic [10:0] h, input logic [9:0] v, input logic rst, input logic wv,
                      input logic [8:0] bh, input logic [7:0] bv, input logic bd);
    @(negedge clk_in);
    hcount_in = h; vcount_in = v; rst_in = rst;
    bin_valid_in = wv; bin_hcount_in = bh; bin_vcount_in = bv; bin_data_in = bd;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(11'd2000, 10'd1000, 1'b1, 1'b0, 9'd0, 8'd0, 1'b0);
  endtask

  task automatic px(input string name, input logic [10:0] h, input logic [9:0] v,
                    input logic ev, input logic ep);
    tick(h, v, 1'b1, 1'b0, 9'd0, 8'd0, 1'b0);
    push(name, cyc + 2, M_PIX, ev, ep, h, v, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [8:0] bh, input logic [7:0] bv, input logic bd);
    tick(11'd2000, 10'd1000, 1'b1, 1'b1, bh, bv, bd);
  endtask

  // Status of the tick just issued, visible one cycle later.
  task automatic st(input string name, input logic swp, input logic drp);
    push(name, cyc + 1, M_ST, 1'b0, 1'b0, 11'd0, 10'd0, swp, drp);
  endtask

  task automatic sweep(input string name);
    logic [10:0] hs [10];
    logic [9:0]  vs [10];
    hs = '{11'd0, 11'd1, 11'd3, 11'd4, 11'd639, 11'd1278, 11'd1279, 11'd1280, 11'd1281, 11'd2047};
    vs = '{10'd0, 10'd1, 10'd3, 10'd4, 10'd359, 10'd718, 10'd719, 10'd720, 10'd721, 10'd1023};
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < 10; j++)
        px(name, hs[j], vs[i], (hs[j] < 11'd1280) && (vs[i] < 10'd720), 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick(11'd2000, 10'd1000, 1'b0, 1'b0, 9'd0, 8'd0, 1'b0);
    tick(11'd2000, 10'd1000, 1'b0, 1'b0, 9'd0, 8'd0, 1'b0);
    push("reset", cyc + 1, M_ALL, 1'b0, 1'b0, 11'd0, 10'd0, 1'b0, 1'b0);

    // Pre-swap blanking
    sweep("blank");
    st("blank_status", 1'b0, 1'b0);

    // Checkerboard (bin value = (h^v)&1)
    wr(9'd0, 8'd0, 1'b0); wr(9'd1, 8'd0, 1'b1); wr(9'd0, 8'd1, 1'b1);
    wr(9'd1, 8'd1, 1'b0); wr(9'd1, 8'd2, 1'b1); wr(9'd319, 8'd179, 1'b0);
    st("cb_no_drop", 1'b0, 1'b0);
    px("cb_0_0", 11'd0, 10'd0, 1'b1, 1'b0);  st("cb_swap", DB, 1'b0);
    px("cb_5_9", 11'd5, 10'd9, 1'b1, 1'b1);  st("cb_swap_once", 1'b0, 1'b0);
    px("cb_4_4", 11'd4, 10'd4, 1'b1, 1'b0);
    px("cb_4_8", 11'd4, 10'd8, 1'b1, 1'b1);
    px("cb_0_4", 11'd0, 10'd4, 1'b1, 1'b1);
    px("cb_4_0", 11'd4, 10'd0, 1'b1, 1'b1);
    px("cb_0_0_again", 11'd0, 10'd0, 1'b1, 1'b0); st("cb_no_reswap", 1'b0, 1'b0);

    // Out of range
    px("oor_pix", 11'd1300, 10'd100, 1'b0, 1'b0);
    wr(9'd320, 8'd0, 1'b0); st("oor_wr_nodrop", 1'b0, 1'b0);
    wr(9'd0, 8'd180, 1'b0);
    px("oor_keep", 11'd0, 10'd4, 1'b1, 1'b1);

    // Drop while a completed frame waits for swap
    wr(9'd0, 8'd0, 1'b0); wr(9'd319, 8'd179, 1'b1); st("drop_before", 1'b0, 1'b0);
    wr(9'd0, 8'd0, 1'b1); st("drop_set", 1'b0, DB);
    px("drop_0_0", 11'd0, 10'd0, 1'b1, !DB); st("drop_swap", DB, DB);

    // Last bin coincides with display (0,0): swap deferred one frame
    tick(11'd0, 10'd0, 1'b1, 1'b1, 9'd319, 8'd179, 1'b1);
    push("co_0_0", cyc + 2, M_PIX, 1'b1, !DB, 11'd0, 10'd0, 1'b0, 1'b0);
    st("co_no_swap", 1'b0, DB);
    idle(2);
    px("co_0_0_next", 11'd0, 10'd0, 1'b1, !DB); st("co_swap", DB, DB);
    px("co_last", 11'd1279, 10'd719, 1'b1, 1'b1); st("co_swap_once", 1'b0, DB);

    // Mid-frame reset
    idle(3);
    tick(11'd640, 10'd360, 1'b0, 1'b0, 9'd0, 8'd0, 1'b0);
    push("mid_reset", cyc + 1, M_ALL, 1'b0, 1'b0, 11'd0, 10'd0, 1'b0, 1'b0);
    sweep("blank2");
    st("post_reset_status", 1'b0, 1'b0);
    wr(9'd319, 8'd179, 1'b0);
    px("rb_0_0", 11'd0, 10'd0, 1'b1, !DB); st("rb_swap", DB, 1'b0);
    px("rb_last", 11'd1279, 10'd719, 1'b1, 1'b0);

    idle(4);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
